// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and defaults.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pipe_pkg;

  // Occupancy of an inter-stage register: nothing, main only, main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  // Natural payload width: {IR, PC}.
  localparam int PIPE_DATA_W_DEFAULT = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug.
// Latency: value updates one cycle after inc is sampled.
// Backpressure: none; sticks at all-ones until reset.
// Ports: clk, rst_n (async active-low), inc (count this cycle), value (current count).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (inc && (value != {CNT_W{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and optional 2-entry skid buffer.
// Latency: 1 cycle in_data -> out_data; full throughput with no bubbles in either mode.
// Backpressure: SKID=1 absorbs one extra beat and drops in_ready from state; SKID=0 in_ready = !out_valid | out_ready.
// Ports: clk, rst_n (async active-low), flush (sync squash), in_valid/in_ready/in_data (upstream),
//        out_valid/out_ready/out_data (downstream, data zero when invalid), stall_cnt (saturating stall cycles).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W_DEFAULT,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_t      state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              accept;
  logic              consume;

  assign out_valid = (state != ST_EMPTY);
  // main_q is cleared whenever the stage empties, so a bubble never carries stale data.
  assign out_data  = main_q;

  // With the skid entry the ready only depends on occupancy, breaking the
  // combinational ready path back up the pipeline.
  assign in_ready = SKID ? (state != ST_FULL) : (!out_valid || out_ready);

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Any same-cycle input is squashed along with the upstream stage.
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q <= in_data;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && consume) begin
            main_q <= in_data;
          end else if (accept && SKID) begin
            // Downstream stalled while a new beat arrived: park it behind main.
            skid_q <= in_data;
            state  <= ST_FULL;
          end else if (consume) begin
            main_q <= '0;
            state  <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            // Older skid entry moves up before anything newer is taken.
            main_q <= skid_q;
            skid_q <= '0;
            state  <= ST_BUSY;
          end
        end
        default: begin
          state  <= ST_EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .value (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // DUT A: skid buffer, 4-bit stall counter
  logic        a_flush = 1'b0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [63:0] a_in_data = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [63:0] a_out_data;
  logic [3:0]  a_stall;

  // DUT B: single register, combinational ready
  logic        b_flush = 1'b0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [63:0] b_in_data = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [63:0] b_out_data;
  logic [3:0]  b_stall;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .SKID(1'b1), .CNT_W(4)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .stall_cnt (a_stall)
  );

  pipe_stage_reg #(.DATA_W(64), .SKID(1'b0), .CNT_W(4)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .stall_cnt (b_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs driven after this are stable for the following edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    #2;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data",  a_out_data,  0);
    chk("rst_a_ready", a_in_ready,  1);
    chk("rst_a_stall", a_stall,     0);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_ready", b_in_ready,  1);
    #10 rst_n = 1'b1;  // released mid-cycle
    cyc();

    // ---------------- 1: streaming through A ----------------
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 64'(i);
      #1;
      chk("stream_ready", a_in_ready, 1);
      chk("stream_valid", a_out_valid, (i == 1) ? 64'd0 : 64'd1);
      chk("stream_data",  a_out_data,  64'(i - 1));
      cyc();
    end
    a_in_valid = 1'b0;
    #1;
    chk("stream_last_data", a_out_data, 64'h8);
    cyc();
    chk("stream_drain_valid", a_out_valid, 0);
    chk("stream_drain_data",  a_out_data,  0);
    chk("stream_stall", a_stall, 0);

    // ---------------- 2: back-pressure with skid ----------------
    a_in_valid = 1'b1; a_in_data = 64'hA; a_out_ready = 1'b1;
    cyc();
    a_in_data = 64'hB; a_out_ready = 1'b0;
    #1;
    chk("bp_busy_ready", a_in_ready, 1);
    chk("bp_busy_data",  a_out_data, 64'hA);
    cyc();
    a_in_data = 64'hC;
    #1;
    chk("bp_full_ready", a_in_ready, 0);
    chk("bp_full_data",  a_out_data, 64'hA);
    chk("bp_full_valid", a_out_valid, 1);
    cyc();
    chk("bp_stall2", a_stall, 2);
    a_out_ready = 1'b1;  // release; C still offered
    #1;
    chk("bp_ready_registered", a_in_ready, 0);
    chk("bp_out0", a_out_data, 64'hA);
    cyc();
    #1;
    chk("bp_out1", a_out_data, 64'hB);
    chk("bp_out1_ready", a_in_ready, 1);
    cyc();
    a_in_valid = 1'b0;
    #1;
    chk("bp_out2", a_out_data, 64'hC);
    cyc();
    chk("bp_empty", a_out_valid, 0);
    chk("bp_stall_end", a_stall, 2);

    // ---------------- 3: flush in FULL ----------------
    a_in_valid = 1'b1; a_in_data = 64'h11; a_out_ready = 1'b0;
    cyc();
    a_in_data = 64'h22;
    cyc();
    a_flush = 1'b1; a_in_data = 64'hDEAD;
    #1;
    chk("fl_full_ready", a_in_ready, 0);
    chk("fl_full_data",  a_out_data, 64'h11);
    cyc();
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1;
    chk("fl_valid", a_out_valid, 0);
    chk("fl_data",  a_out_data,  0);
    chk("fl_ready", a_in_ready,  1);
    a_out_ready = 1'b1;
    cyc();
    chk("fl_no_dead_valid", a_out_valid, 0);
    chk("fl_no_dead_data",  a_out_data,  0);
    chk("fl_stall", a_stall, 4);

    // ---------------- 4: SKID=0 stall ----------------
    b_in_valid = 1'b1; b_in_data = 64'h21; b_out_ready = 1'b1;
    cyc();
    b_in_data = 64'h22;
    #1;
    chk("b_stream0", b_out_data, 64'h21);
    chk("b_stream_ready", b_in_ready, 1);
    cyc();
    b_in_data = 64'h1234;
    #1;
    chk("b_stream1", b_out_data, 64'h22);
    cyc();
    b_in_data = 64'h5678; b_out_ready = 1'b0;
    #1;
    chk("b_stall_ready_same_cycle", b_in_ready, 0);
    chk("b_stall_data", b_out_data, 64'h1234);
    cyc();
    chk("b_hold_data",  b_out_data, 64'h1234);
    chk("b_hold_valid", b_out_valid, 1);
    chk("b_stall_cnt",  b_stall, 1);
    b_out_ready = 1'b1;
    #1;
    chk("b_release_ready", b_in_ready, 1);
    cyc();
    b_in_valid = 1'b0;
    #1;
    chk("b_resume_data", b_out_data, 64'h5678);
    cyc();
    chk("b_empty_valid", b_out_valid, 0);
    chk("b_empty_data",  b_out_data,  0);
    b_out_ready = 1'b0;

    // ---------------- 5: stall counter saturation (A) ----------------
    a_in_valid = 1'b1; a_in_data = 64'h55; a_out_ready = 1'b0;
    cyc();
    a_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 10) chk("sat_k10", a_stall, 14);
      if (k == 11) chk("sat_k11", a_stall, 15);
    end
    chk("sat_hold", a_stall, 15);
    chk("sat_data", a_out_data, 64'h55);
    a_flush = 1'b1;
    cyc();
    a_flush = 1'b0;
    chk("sat_after_flush", a_stall, 15);
    chk("sat_flush_valid", a_out_valid, 0);

    // ---------------- 6: async reset in FULL ----------------
    a_in_valid = 1'b1; a_in_data = 64'h66; a_out_ready = 1'b0;
    cyc();
    a_in_data = 64'h77;
    cyc();
    a_in_valid = 1'b0;
    #1;
    chk("ar_full_ready", a_in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", a_out_valid, 0);
    chk("ar_data",  a_out_data,  0);
    chk("ar_stall", a_stall,     0);
    chk("ar_ready", a_in_ready,  1);
    #1 rst_n = 1'b1;
    cyc();
    a_in_valid = 1'b1; a_in_data = 64'h99; a_out_ready = 1'b1;
    #1;
    chk("ar_pre_valid", a_out_valid, 0);
    cyc();
    a_in_valid = 1'b0;
    #1;
    chk("ar_first_valid", a_out_valid, 1);
    chk("ar_first_data",  a_out_data,  64'h99);
    cyc();
    chk("ar_drain_valid", a_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
